// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC-to-UART reporter: ASCII constants, FSM states,
// frame geometry and the BCD-digit-to-ASCII mapping.
package rtc_pkg;

    localparam logic [7:0] CHR_T     = 8'h54;
    localparam logic [7:0] CHR_I     = 8'h69;
    localparam logic [7:0] CHR_M     = 8'h6D;
    localparam logic [7:0] CHR_E     = 8'h65;
    localparam logic [7:0] CHR_S     = 8'h73;
    localparam logic [7:0] CHR_COLON = 8'h3A;
    localparam logic [7:0] CHR_DASH  = 8'h2D;
    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_QMARK = 8'h3F;
    localparam logic [7:0] CHR_ZERO  = 8'h30;

    localparam int FRAME_LEN_TIME = 18;
    localparam int FRAME_LEN_DATE = 27;
    localparam int DATE_FIELD_LEN = FRAME_LEN_DATE - FRAME_LEN_TIME;
    localparam int IDX_W          = 5;
    localparam int GAP_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_t;

    // Field order matches the concatenation used when the snapshot is taken.
    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } stamp_t;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
        return (nib > 4'd9) ? CHR_QMARK : (CHR_ZERO | {4'h0, nib});
    endfunction

endpackage

// File: rtl/rtc_char_rom.sv
// Combinational character generator: byte index k of the report frame, built
// from the frozen time/date snapshot.
module rtc_char_rom
    import rtc_pkg::*;
#(
    parameter bit SHOW_DATE = 1'b0
) (
    input  logic [IDX_W-1:0] k,
    input  logic [47:0]      snap,
    output logic [7:0]       ch
);

    stamp_t           s;
    logic [IDX_W-1:0] pos;

    assign s = snap;

    // Positions are laid out for the full dated frame; without the date the
    // index simply skips over the date field.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pos = k;
        if (!SHOW_DATE && (k >= IDX_W'(8))) begin
            pos = k + IDX_W'(DATE_FIELD_LEN);
        end

        ch = 8'h00;
        case (pos)
            5'd0:  ch = CHR_T;
            5'd1:  ch = CHR_I;
            5'd2:  ch = CHR_M;
            5'd3:  ch = CHR_E;
            5'd4:  ch = CHR_SPACE;
            5'd5:  ch = CHR_I;
            5'd6:  ch = CHR_S;
            5'd7:  ch = CHR_SPACE;
            5'd8:  ch = bcd_to_ascii(s.year[7:4]);
            5'd9:  ch = bcd_to_ascii(s.year[3:0]);
            5'd10: ch = CHR_DASH;
            5'd11: ch = bcd_to_ascii(s.month[7:4]);
            5'd12: ch = bcd_to_ascii(s.month[3:0]);
            5'd13: ch = CHR_DASH;
            5'd14: ch = bcd_to_ascii(s.day[7:4]);
            5'd15: ch = bcd_to_ascii(s.day[3:0]);
            5'd16: ch = CHR_SPACE;
            5'd17: ch = bcd_to_ascii(s.hour[7:4]);
            5'd18: ch = bcd_to_ascii(s.hour[3:0]);
            5'd19: ch = CHR_COLON;
            5'd20: ch = bcd_to_ascii(s.minute[7:4]);
            5'd21: ch = bcd_to_ascii(s.minute[3:0]);
            5'd22: ch = CHR_COLON;
            5'd23: ch = bcd_to_ascii(s.second[7:4]);
            5'd24: ch = bcd_to_ascii(s.second[3:0]);
            5'd25: ch = CHR_LF;
            5'd26: ch = CHR_CR;
            default: ch = 8'h00;
        endcase
    end

endmodule

// File: rtl/rtc_uart_reporter.sv
// Formats the DS1302 time (and optionally date) as an ASCII line and streams it
// byte by byte to uarttx, paced by CHAR_GAP and optionally by tx_idle.
module rtc_uart_reporter
    import rtc_pkg::*;
#(
    parameter int CHAR_GAP  = 255,
    parameter bit USE_IDLE  = 1'b1,
    parameter bit SHOW_DATE = 1'b0
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       en,
    input  logic       force_req,
    input  logic [7:0] time_second,
    input  logic [7:0] time_minute,
    input  logic [7:0] time_hour,
    input  logic [7:0] date_day,
    input  logic [7:0] date_month,
    input  logic [7:0] date_year,
    input  logic       tx_idle,
    output logic [7:0] txdata,
    output logic       wrsig,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX   = SHOW_DATE ? IDX_W'(FRAME_LEN_DATE - 1)
                                                        : IDX_W'(FRAME_LEN_TIME - 1);
    // SEND occupies one cycle, so WAIT counts the remaining CHAR_GAP-1 cycles.
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CHAR_GAP - 2);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             pending_q, pending_d;
    logic [7:0]       sec_prev_q;
    stamp_t           snap_q, snap_d;
    logic             trigger;
    logic [7:0]       rom_char;

    assign trigger = force_req | (en & (time_second != sec_prev_q));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RSTn) begin
            state_q    <= IDLE;
            k_q        <= '0;
            gap_q      <= '0;
            pending_q  <= 1'b0;
            sec_prev_q <= 8'hFF;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            sec_prev_q <= time_second;
        end
    end

    // NOTE: the snapshot is pure datapath, always written in LOAD before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        gap_d      = gap_q;
        pending_d  = pending_q;
        snap_d     = snap_q;
        txdata     = 8'h00;
        wrsig      = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;

        if (trigger && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (trigger) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                snap_d  = {date_year, date_month, date_day, time_hour, time_minute, time_second};
                k_d     = '0;
                state_d = SEND;
            end
            SEND: begin
                wrsig   = 1'b1;
                txdata  = rom_char;
                gap_d   = GAP_RELOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (!USE_IDLE || tx_idle) begin
                    if (k_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + IDX_W'(1);
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                // A trigger landing on this cycle is folded into the pending frame.
                pending_d  = 1'b0;
                state_d    = (pending_q || trigger) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    rtc_char_rom #(
        .SHOW_DATE(SHOW_DATE)
    ) u_char_rom (
        .k   (k_q),
        .snap(snap_q),
        .ch  (rom_char)
    );

endmodule

// File: tb/tb_rtc_uart_reporter.sv
// Scoreboard bench for rtc_uart_reporter: two instances (time-only with pure gap
// pacing, dated with idle handshake) checked byte by byte against a queue.
module tb_rtc_uart_reporter;

    localparam int GAP_A = 255;
    localparam int GAP_B = 32;

    typedef struct {
        logic [7:0] ch;
        bit         first;
    } exp_t;

    logic clk = 1'b0;
    logic RSTn;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic       en_a, force_a, tx_idle_a;
    logic [7:0] sec_a, min_a, hour_a, day_a, mon_a, year_a;
    logic [7:0] txdata_a;
    logic       wrsig_a, busy_a, frame_done_a;

    logic       en_b, force_b, tx_idle_b;
    logic [7:0] sec_b, min_b, hour_b, day_b, mon_b, year_b;
    logic [7:0] txdata_b;
    logic       wrsig_b, busy_b, frame_done_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   last_wr_a = 0;
    int   last_wr_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_uart_reporter #(.CHAR_GAP(GAP_A), .USE_IDLE(1'b0), .SHOW_DATE(1'b0)) dut_a (
        .clk(clk), .RSTn(RSTn), .en(en_a), .force_req(force_a),
        .time_second(sec_a), .time_minute(min_a), .time_hour(hour_a),
        .date_day(day_a), .date_month(mon_a), .date_year(year_a),
        .tx_idle(tx_idle_a), .txdata(txdata_a), .wrsig(wrsig_a),
        .busy(busy_a), .frame_done(frame_done_a)
    );

    rtc_uart_reporter #(.CHAR_GAP(GAP_B), .USE_IDLE(1'b1), .SHOW_DATE(1'b1)) dut_b (
        .clk(clk), .RSTn(RSTn), .en(en_b), .force_req(force_b),
        .time_second(sec_b), .time_minute(min_b), .time_hour(hour_b),
        .date_day(day_b), .date_month(mon_b), .date_year(year_b),
        .tx_idle(tx_idle_b), .txdata(txdata_b), .wrsig(wrsig_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        if (n > 4'd9) return 8'h3F;
        return 8'h30 + {4'h0, n};
    endfunction

    task automatic push_frame(input bit to_b, input bit with_date,
                              input logic [7:0] yy, mo, dd, hh, mi, ss);
        logic [7:0] f[$];
        exp_t       e;
        f = '{8'h54, 8'h69, 8'h6D, 8'h65, 8'h20, 8'h69, 8'h73, 8'h20};
        if (with_date) begin
            f.push_back(asc(yy[7:4])); f.push_back(asc(yy[3:0])); f.push_back(8'h2D);
            f.push_back(asc(mo[7:4])); f.push_back(asc(mo[3:0])); f.push_back(8'h2D);
            f.push_back(asc(dd[7:4])); f.push_back(asc(dd[3:0])); f.push_back(8'h20);
        end
        f.push_back(asc(hh[7:4])); f.push_back(asc(hh[3:0])); f.push_back(8'h3A);
        f.push_back(asc(mi[7:4])); f.push_back(asc(mi[3:0])); f.push_back(8'h3A);
        f.push_back(asc(ss[7:4])); f.push_back(asc(ss[3:0]));
        f.push_back(8'h0A); f.push_back(8'h0D);
        foreach (f[i]) begin
            e.ch    = f[i];
            e.first = (i == 0);
            if (to_b) q_b.push_back(e);
            else      q_a.push_back(e);
        end
    endtask

    task automatic wait_wr(input bit b, input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge clk);
            if (b ? wrsig_b : wrsig_a) seen++;
        end
        if (seen < n) check(b ? "b_wr_timeout" : "a_wr_timeout", seen, n);
    endtask

    task automatic wait_done(input bit b, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (b ? frame_done_b : frame_done_a) got = 1'b1;
        end
        if (!got) check(b ? "b_done_timeout" : "a_done_timeout", b ? frame_done_b : frame_done_a, 1);
    endtask

    // Scoreboard for the time-only instance: bytes, exact spacing, frame end.
    always @(negedge clk) begin
        if (wrsig_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_wr", {24'h0, txdata_a}, 32'hFFFF_FFFF);
            end else begin
                e_a = q_a.pop_front();
                check("a_byte", txdata_a, e_a.ch);
                if (!e_a.first) check("a_gap", cyc - last_wr_a, GAP_A);
                last_wr_a = cyc;
            end
        end
        if (frame_done_a === 1'b1) begin
            check("a_done_at_boundary", (q_a.size() == 0) || q_a[0].first, 1);
            check("a_done_gap", cyc - last_wr_a, GAP_A);
        end
    end

    // Scoreboard for the dated instance: bytes, minimum spacing, frame end.
    always @(negedge clk) begin
        if (wrsig_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_wr", {24'h0, txdata_b}, 32'hFFFF_FFFF);
            end else begin
                e_b = q_b.pop_front();
                check("b_byte", txdata_b, e_b.ch);
                if (!e_b.first) check("b_gap_min", (cyc - last_wr_b) >= GAP_B, 1);
                last_wr_b = cyc;
            end
        end
        if (frame_done_b === 1'b1) begin
            check("b_done_at_boundary", (q_b.size() == 0) || q_b[0].first, 1);
        end
    end

    initial begin
        int cnt;
        RSTn = 1'b0;
        en_a = 1'b0; force_a = 1'b0; tx_idle_a = 1'b1;
        sec_a = 8'h00; min_a = 8'h00; hour_a = 8'h00; day_a = 8'h01; mon_a = 8'h01; year_a = 8'h00;
        en_b = 1'b0; force_b = 1'b0; tx_idle_b = 1'b1;
        sec_b = 8'h00; min_b = 8'h00; hour_b = 8'h00; day_b = 8'h01; mon_b = 8'h01; year_b = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_wrsig", wrsig_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_txdata", txdata_a, 0);
        check("rst_frame_done", frame_done_a, 0);
        check("rst_b_busy", busy_b, 0);
        RSTn = 1'b1;

        // Seconds change 56 -> 57 with en=1.
        hour_a = 8'h12; min_a = 8'h34; sec_a = 8'h56;
        repeat (2) @(negedge clk);
        en_a = 1'b1;
        repeat (3) @(negedge clk);
        check("a_no_trigger_steady", busy_a, 0);
        push_frame(0, 0, 0, 0, 0, 8'h12, 8'h34, 8'h57);
        sec_a = 8'h57;
        wait_done(0, 18 * GAP_A + 50);
        @(negedge clk);
        check("a_busy_after_done", busy_a, 0);
        check("a_done_one_cycle", frame_done_a, 0);
        check("a_queue_drained", q_a.size(), 0);

        // Invalid BCD hour is reported as '1','?'.
        hour_a = 8'h1A;
        push_frame(0, 0, 0, 0, 0, 8'h1A, 8'h34, 8'h57);
        @(negedge clk); force_a = 1'b1;
        @(negedge clk); force_a = 1'b0;
        wait_done(0, 18 * GAP_A + 50);
        check("a_badbcd_drained", q_a.size(), 0);

        // Snapshot holds while second moves; pending frame follows; extra triggers merge.
        @(negedge clk);
        hour_a = 8'h12;
        push_frame(0, 0, 0, 0, 0, 8'h12, 8'h34, 8'h10);
        sec_a = 8'h10;
        wait_wr(0, 4, 4 * GAP_A + 50);
        push_frame(0, 0, 0, 0, 0, 8'h12, 8'h34, 8'h11);
        sec_a = 8'h11;
        wait_wr(0, 3, 3 * GAP_A + 50);
        force_a = 1'b1;
        @(negedge clk); force_a = 1'b0;
        wait_done(0, 18 * GAP_A + 50);
        @(negedge clk);
        check("a_pending_load_busy", busy_a, 1);
        check("a_pending_load_nowr", wrsig_a, 0);
        @(negedge clk);
        check("a_pending_immediate_wr", wrsig_a, 1);
        wait_done(0, 18 * GAP_A + 50);
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (wrsig_a) cnt++;
        end
        check("a_no_third_frame", cnt, 0);
        check("a_idle_after_pending", busy_a, 0);

        // Reset during byte 10 aborts; the first second after reset restarts at byte 0.
        push_frame(0, 0, 0, 0, 0, 8'h12, 8'h34, 8'h12);
        sec_a = 8'h12;
        wait_wr(0, 11, 11 * GAP_A + 50);
        #1;
        RSTn = 1'b0;
        q_a.delete();
        push_frame(0, 0, 0, 0, 0, 8'h12, 8'h34, 8'h12);
        @(negedge clk);
        check("a_midrst_wrsig", wrsig_a, 0);
        check("a_midrst_busy", busy_a, 0);
        check("a_midrst_txdata", txdata_a, 0);
        check("a_midrst_done", frame_done_a, 0);
        RSTn = 1'b1;
        wait_done(0, 18 * GAP_A + 50);
        check("a_restart_drained", q_a.size(), 0);

        // Dated frame from force_req with en=0; first byte two cycles after the request.
        year_b = 8'h24; mon_b = 8'h07; day_b = 8'h15;
        hour_b = 8'h09; min_b = 8'h05; sec_b = 8'h00;
        push_frame(1, 1, 8'h24, 8'h07, 8'h15, 8'h09, 8'h05, 8'h00);
        @(negedge clk); force_b = 1'b1;
        @(negedge clk); force_b = 1'b0;
        check("b_latency_load", wrsig_b, 0);
        @(negedge clk);
        check("b_latency_first_wr", wrsig_b, 1);
        wait_done(1, 27 * GAP_B + 50);
        check("b_date_drained", q_b.size(), 0);

        // tx_idle low after byte 0 stalls byte 1 until it returns.
        push_frame(1, 1, 8'h24, 8'h07, 8'h15, 8'h09, 8'h05, 8'h00);
        @(negedge clk); force_b = 1'b1;
        @(negedge clk); force_b = 1'b0;
        wait_wr(1, 1, 10);
        tx_idle_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wrsig_b) cnt++;
        end
        check("b_no_wr_while_busy_tx", cnt, 0);
        check("b_still_busy", busy_b, 1);
        tx_idle_b = 1'b1;
        @(negedge clk);
        check("b_resume_wr", wrsig_b, 1);
        wait_done(1, 27 * GAP_B + 50);
        check("b_idle_drained", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
